hfosc_power_sequencer: RTL and testbench



---
 rtl/hfosc_power_sequencer.sv | 153 +++++++++++++++
 tb/tb_hfosc_power_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hfosc_power_sequencer.sv
// High-frequency oscillator power sequencer: wake arbitration, startup delay, idle power-down, minimum off time.
// Optional boot hold on stack-pointer match is enabled by defining HFOSC_SP_BOOT_HOLD_EN.
module hfosc_power_sequencer #(
   parameter int STARTUP_CYCLES = 16,
   parameter int IDLE_CYCLES    = 64,
   parameter int OFF_HOLD       = 4,
`ifdef HFOSC_SP_BOOT_HOLD_EN
   parameter logic [31:0] SP_BOOT_VALUE = 32'h1000,
`endif
   parameter int NREQ           = 4
) (
`ifdef HFOSC_SP_BOOT_HOLD_EN
   input  logic [31:0]     rdsp,
`endif
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            force_on,
   output logic [NREQ-1:0] grant,
   output logic            clkhf_powerup,
   output logic            clkhf_enable,
   output logic            hf_ready,
   output logic [2:0]      state_o
);

   localparam logic [2:0] S_OFF   = 3'd0;
   localparam logic [2:0] S_PWRUP = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_IDLE  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   localparam int MAX_SU = (STARTUP_CYCLES > IDLE_CYCLES) ? STARTUP_CYCLES : IDLE_CYCLES;
   localparam int MAXC   = (MAX_SU > OFF_HOLD) ? MAX_SU : OFF_HOLD;
   localparam int CW     = $clog2(MAXC + 1);

   localparam logic [CW-1:0] START_LD = CW'(STARTUP_CYCLES - 1);
   localparam logic [CW-1:0] IDLE_LD  = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(OFF_HOLD - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            demand;
   logic            hf_on;

`ifdef HFOSC_SP_BOOT_HOLD_EN
   logic [1:0] bcnt_q, bcnt_d;
   logic       boot_hold_q, boot_hold_d;

   // boot_hold drops on the same edge the match counter saturates
   always_comb begin
      bcnt_d      = bcnt_q;
      if ((rdsp == SP_BOOT_VALUE) && (bcnt_q != 2'd2))
         bcnt_d   = bcnt_q + 2'd1;
      boot_hold_d = boot_hold_q & (bcnt_d != 2'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt_q      <= 2'd0;
         boot_hold_q <= 1'b1;
      end else begin
         bcnt_q      <= bcnt_d;
         boot_hold_q <= boot_hold_d;
      end
   end

   assign demand = (|req) | force_on | boot_hold_q;
`else
   assign demand = (|req) | force_on;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF: if (demand) begin
            state_d = S_PWRUP;
            cnt_d   = START_LD;
         end
         // startup never aborts, even if demand vanishes
         S_PWRUP: if (cnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q - ONE;
         end
         S_RUN: if (!demand) begin
            state_d = S_IDLE;
            cnt_d   = IDLE_LD;
         end
         S_IDLE: if (demand) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end else if (cnt_q == '0) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q - ONE;
         end
         S_DRAIN: begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
         end
         // demand seen during DRAIN/HOLD is honoured once the off time expires
         S_HOLD: if (cnt_q == '0) begin
            state_d = demand ? S_PWRUP : S_OFF;
            cnt_d   = demand ? START_LD : '0;
         end else begin
            cnt_d   = cnt_q - ONE;
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   assign hf_on   = (state_q == S_RUN) || (state_q == S_IDLE);
   assign grant_d = req & {NREQ{hf_on}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      clkhf_powerup = 1'b0;
      clkhf_enable  = 1'b0;
      case (state_q)
         S_PWRUP, S_DRAIN: clkhf_powerup = 1'b1;
         S_RUN, S_IDLE: begin
            clkhf_powerup = 1'b1;
            clkhf_enable  = 1'b1;
         end
         default: ;
      endcase
   end

   assign hf_ready = hf_on;
   assign grant    = grant_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_hfosc_power_sequencer.sv
// Directed, table-driven bench for hfosc_power_sequencer (default parameters).
// Defining HFOSC_SP_BOOT_HOLD_EN switches to the boot-hold scenarios.
module tb_hfosc_power_sequencer;

   localparam logic [2:0] S_OFF = 3'd0, S_PW = 3'd1, S_RUN = 3'd2,
                          S_IDLE = 3'd3, S_DRN = 3'd4, S_HOLD = 3'd5;

   typedef struct {
      int          cyc;
      logic [3:0]  req;
      logic        fo;
      logic [31:0] rdsp;
      logic [2:0]  st;
      logic [3:0]  gnt;
      logic        pu;
      logic        en;
      logic        rdy;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic        force_on;
   logic [3:0]  grant;
   logic        clkhf_powerup, clkhf_enable, hf_ready;
   logic [2:0]  state_o;
`ifdef HFOSC_SP_BOOT_HOLD_EN
   logic [31:0] rdsp;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   hfosc_power_sequencer dut (
`ifdef HFOSC_SP_BOOT_HOLD_EN
      .rdsp          (rdsp),
`endif
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .force_on      (force_on),
      .grant         (grant),
      .clkhf_powerup (clkhf_powerup),
      .clkhf_enable  (clkhf_enable),
      .hf_ready      (hf_ready),
      .state_o       (state_o)
   );

   function automatic vec_t mk(int c, logic [3:0] r, logic f, logic [31:0] d,
                               logic [2:0] s, logic [3:0] g, logic pu, logic en, logic rdy);
      vec_t v;
      v.cyc = c; v.req = r; v.fo = f; v.rdsp = d;
      v.st = s; v.gnt = g; v.pu = pu; v.en = en; v.rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got st=%0d gnt=%b pu=%b en=%b rdy=%b, expected st=%0d gnt=%b pu=%b en=%b rdy=%b",
                  name, got[9:7], got[6:3], got[2], got[1], got[0],
                  exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [9:0] outs();
      return {state_o, grant, clkhf_powerup, clkhf_enable, hf_ready};
   endfunction

   // Advance to the vector's cycle, check outputs there, then drive its inputs
   task automatic run_vecs();
      foreach (vecs[i]) begin
         while (cyc < vecs[i].cyc) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         chk($sformatf("cycle %0d", vecs[i].cyc), outs(),
             {vecs[i].st, vecs[i].gnt, vecs[i].pu, vecs[i].en, vecs[i].rdy});
         req      = vecs[i].req;
         force_on = vecs[i].fo;
`ifdef HFOSC_SP_BOOT_HOLD_EN
         rdsp     = vecs[i].rdsp;
`endif
      end
      vecs.delete();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      force_on = 1'b0;
`ifdef HFOSC_SP_BOOT_HOLD_EN
      rdsp     = '0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset state", outs(), 10'd0);
      reset = 1'b0;
      cyc   = 0;
   endtask

   initial begin
`ifndef HFOSC_SP_BOOT_HOLD_EN
      do_reset();
      // cold start, idle timeout, request during DRAIN, re-wake from IDLE, force_on
      vecs.push_back(mk(  0, 4'h1, 0, 0, S_OFF,  4'h0, 0, 0, 0));
      vecs.push_back(mk(  1, 4'h1, 0, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk( 16, 4'h1, 0, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk( 17, 4'h1, 0, 0, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk( 18, 4'h1, 0, 0, S_RUN,  4'h1, 1, 1, 1));
      vecs.push_back(mk( 30, 4'h0, 0, 0, S_RUN,  4'h1, 1, 1, 1));
      vecs.push_back(mk( 31, 4'h0, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk( 94, 4'h0, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk( 95, 4'h2, 0, 0, S_DRN,  4'h0, 1, 0, 0));
      vecs.push_back(mk( 96, 4'h2, 0, 0, S_HOLD, 4'h0, 0, 0, 0));
      vecs.push_back(mk( 99, 4'h2, 0, 0, S_HOLD, 4'h0, 0, 0, 0));
      vecs.push_back(mk(100, 4'h2, 0, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk(105, 4'h0, 0, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk(115, 4'h0, 0, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk(116, 4'h0, 0, 0, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(117, 4'h0, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk(130, 4'h4, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk(131, 4'h4, 0, 0, S_RUN,  4'h4, 1, 1, 1));
      vecs.push_back(mk(135, 4'h0, 0, 0, S_RUN,  4'h4, 1, 1, 1));
      vecs.push_back(mk(136, 4'h0, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk(199, 4'h0, 0, 0, S_IDLE, 4'h0, 1, 1, 1));
      vecs.push_back(mk(200, 4'h0, 0, 0, S_DRN,  4'h0, 1, 0, 0));
      vecs.push_back(mk(201, 4'h0, 0, 0, S_HOLD, 4'h0, 0, 0, 0));
      vecs.push_back(mk(204, 4'h0, 0, 0, S_HOLD, 4'h0, 0, 0, 0));
      vecs.push_back(mk(205, 4'h0, 0, 0, S_OFF,  4'h0, 0, 0, 0));
      vecs.push_back(mk(210, 4'h0, 1, 0, S_OFF,  4'h0, 0, 0, 0));
      vecs.push_back(mk(211, 4'h0, 1, 0, S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk(227, 4'h0, 1, 0, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(240, 4'hF, 1, 0, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(241, 4'hF, 1, 0, S_RUN,  4'hF, 1, 1, 1));
      run_vecs();

      // asynchronous reset pulse between clock edges
      #2 reset = 1'b1;
      #1 chk("async reset mid-RUN", outs(), 10'd0);
      @(posedge clk);
      #1 chk("reset held across edge", outs(), 10'd0);
      reset = 1'b0;
      cyc   = 0;
      vecs.push_back(mk( 0, 4'hF, 1, 0, S_OFF, 4'h0, 0, 0, 0));
      vecs.push_back(mk( 1, 4'hF, 1, 0, S_PW,  4'h0, 1, 0, 0));
      vecs.push_back(mk(17, 4'hF, 1, 0, S_RUN, 4'h0, 1, 1, 1));
      vecs.push_back(mk(18, 4'hF, 1, 0, S_RUN, 4'hF, 1, 1, 1));
      run_vecs();
`else
      do_reset();
      // two SP matches release boot_hold
      vecs.push_back(mk( 0, 4'h0, 0, 32'h0,    S_OFF,  4'h0, 0, 0, 0));
      vecs.push_back(mk( 1, 4'h0, 0, 32'h0,    S_PW,   4'h0, 1, 0, 0));
      vecs.push_back(mk(17, 4'h0, 0, 32'h0,    S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(20, 4'h0, 0, 32'h1000, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(21, 4'h0, 0, 32'h0,    S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(25, 4'h0, 0, 32'h1000, S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(26, 4'h0, 0, 32'h0,    S_RUN,  4'h0, 1, 1, 1));
      vecs.push_back(mk(27, 4'h0, 0, 32'h0,    S_IDLE, 4'h0, 1, 1, 1));
      run_vecs();

      do_reset();
      // a single match keeps boot_hold set
      vecs.push_back(mk(  0, 4'h0, 0, 32'h0,    S_OFF, 4'h0, 0, 0, 0));
      vecs.push_back(mk( 17, 4'h0, 0, 32'h0,    S_RUN, 4'h0, 1, 1, 1));
      vecs.push_back(mk( 20, 4'h0, 0, 32'h1000, S_RUN, 4'h0, 1, 1, 1));
      vecs.push_back(mk( 21, 4'h0, 0, 32'h0,    S_RUN, 4'h0, 1, 1, 1));
      vecs.push_back(mk(300, 4'h0, 0, 32'h0,    S_RUN, 4'h0, 1, 1, 1));
      run_vecs();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
